tpu_seq_ctrl: RTL and testbench

TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

---
 rtl/tpu_pkg.sv | 37 +++
 rtl/tpu_seq_ctrl_if.sv | 27 ++
 rtl/tpu_skew_feeder.sv | 35 +++
 rtl/tpu_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array sequencer: mode codes, FSM states, status bit positions.
package tpu_pkg;

    localparam logic [1:0] MODE_LOAD_A  = 2'b00;
    localparam logic [1:0] MODE_LOAD_B  = 2'b01;
    localparam logic [1:0] MODE_COMPUTE = 2'b10;
    localparam logic [1:0] MODE_READ    = 2'b11;

    localparam int UIO_STROBE   = 2;
    localparam int BIT_BUSY     = 4;
    localparam int BIT_DONE     = 5;
    localparam int BIT_OVF      = 6;
    localparam int BIT_RD_VALID = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_DONE,
        ST_READ
    } state_t;

    function automatic state_t mode_to_state(input logic [1:0] mode);
        state_t s;
        case (mode)
            MODE_LOAD_A:  s = ST_LOAD_A;
            MODE_LOAD_B:  s = ST_LOAD_B;
            MODE_COMPUTE: s = ST_COMPUTE;
            default:      s = ST_READ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tpu_seq_ctrl_if.sv
// Bus between the sequencer (master) and the systolic array (slave): skewed feeds, clear and result chain.
interface tpu_seq_ctrl_if #(
    parameter int N  = 2,
    parameter int DW = 8
);
    logic [N*DW-1:0] sys_a;
    logic [N*DW-1:0] sys_b;
    logic            sys_clr;
    logic            sys_chain_en;
    logic [DW-1:0]   sys_chain_out;

    modport master (
        output sys_a,
        output sys_b,
        output sys_clr,
        output sys_chain_en,
        input  sys_chain_out
    );

    modport slave (
        input  sys_a,
        input  sys_b,
        input  sys_clr,
        input  sys_chain_en,
        output sys_chain_out
    );
endinterface

// File: rtl/tpu_skew_feeder.sv
// Diagonal skew schedule: row lane i carries A[i][t-i], column lane j carries B[t-j][j], zero elsewhere.
module tpu_skew_feeder #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int TW = 2
) (
    input  logic              en,
    input  logic [TW-1:0]     t,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic [N*DW-1:0]   sys_a,
    output logic [N*DW-1:0]   sys_b
);
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_lane;
        logic [DW-1:0] b_lane;

        // At most one k matches t == gi + k, so the loop acts as a mux.
        always_comb begin
            a_lane = '0;
            b_lane = '0;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t) == gi + k) begin
                        a_lane = a_flat[(gi*N + k)*DW +: DW];
                        b_lane = b_flat[(k*N + gi)*DW +: DW];
                    end
                end
            end
        end

        assign sys_a[gi*DW +: DW] = a_lane;
        assign sys_b[gi*DW +: DW] = b_lane;
    end
endmodule

// File: rtl/tpu_seq_ctrl.sv
// Sequencer for an NxN systolic array: byte-serial A/B load, skewed compute feed, strobed result readout.
// Optional sticky overflow flag for dropped load strobes: define TPU_SEQ_CTRL_OVF_EN.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  ui_in,
    input  logic [7:0]     uio_in,
    output logic [DW-1:0]  uo_out,
    output logic [7:0]     uio_out,
    output logic [7:0]     uio_oe,
    tpu_seq_ctrl_if.master arr
);
    localparam int NN     = N * N;
    localparam int IDX_W  = $clog2(NN + 1);
    localparam int T_LAST = 3 * N - 3;
    localparam int T_W    = $clog2(T_LAST + 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NN);
    localparam logic [T_W-1:0]   T_END   = T_W'(T_LAST);

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic             strb_prev_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [T_W-1:0]   t_q, t_d;
    logic             done_q, done_d;
    logic             sys_clr_q, sys_clr_d;
    logic [DW-1:0]    a_mem_q [NN];
    logic [DW-1:0]    a_mem_d [NN];
    logic [DW-1:0]    b_mem_q [NN];
    logic [DW-1:0]    b_mem_d [NN];
    logic [NN*DW-1:0] a_flat, b_flat;

    logic [1:0] mode;
    logic       strobe_evt, mode_chg, wr_a, wr_b, chain_en;
    logic       rd_avail, busy, ovf;
    logic       unused_uio;

    assign mode       = uio_in[1:0];
    assign strobe_evt = uio_in[UIO_STROBE] & ~strb_prev_q;
    // IDLE has no mode of its own, so whatever mode is presented counts as a change.
    assign mode_chg   = (state_q == ST_IDLE) || (mode != mode_q);
    assign unused_uio = ^uio_in[7:3];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        t_d       = t_q;
        done_d    = done_q;
        sys_clr_d = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        chain_en  = 1'b0;
        if (mode_chg) begin
            state_d = mode_to_state(mode);
            idx_d   = '0;
            t_d     = '0;
            // Aborting a compute and starting a fresh load both discard the accumulators.
            if (state_q == ST_COMPUTE || state_d == ST_LOAD_A) begin
                done_d    = 1'b0;
                sys_clr_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_LOAD_A, ST_LOAD_B: begin
                    if (strobe_evt && idx_q < IDX_END) begin
                        wr_a  = (state_q == ST_LOAD_A);
                        wr_b  = (state_q == ST_LOAD_B);
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (t_q == T_END) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                ST_READ: begin
                    if (strobe_evt && idx_q < IDX_END) begin
                        chain_en = 1'b1;
                        idx_d    = idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            strb_prev_q <= 1'b0;
            idx_q       <= '0;
            t_q         <= '0;
            done_q      <= 1'b0;
            sys_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode;
            strb_prev_q <= uio_in[UIO_STROBE];
            idx_q       <= idx_d;
            t_q         <= t_d;
            done_q      <= done_d;
            sys_clr_q   <= sys_clr_d;
        end
    end

    for (genvar gi = 0; gi < NN; gi++) begin : g_mem
        assign a_mem_d[gi] = (wr_a && idx_q == IDX_W'(gi)) ? ui_in : a_mem_q[gi];
        assign b_mem_d[gi] = (wr_b && idx_q == IDX_W'(gi)) ? ui_in : b_mem_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_mem_q[gi] <= '0;
                b_mem_q[gi] <= '0;
            end else begin
                a_mem_q[gi] <= a_mem_d[gi];
                b_mem_q[gi] <= b_mem_d[gi];
            end
        end

        assign a_flat[gi*DW +: DW] = a_mem_q[gi];
        assign b_flat[gi*DW +: DW] = b_mem_q[gi];
    end

`ifdef TPU_SEQ_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (mode_chg && mode == MODE_LOAD_A) begin
            ovf_d = 1'b0;
        end else if (!mode_chg && (state_q == ST_LOAD_A || state_q == ST_LOAD_B)
                     && strobe_evt && idx_q >= IDX_END) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    tpu_skew_feeder #(
        .N  (N),
        .DW (DW),
        .TW (T_W)
    ) u_feeder (
        .en     (state_q == ST_COMPUTE),
        .t      (t_q),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .sys_a  (arr.sys_a),
        .sys_b  (arr.sys_b)
    );

    assign busy             = (state_q == ST_COMPUTE);
    assign rd_avail         = (state_q == ST_READ) && (idx_q < IDX_END);
    assign uo_out           = rd_avail ? arr.sys_chain_out : '0;
    assign uio_oe           = UIO_OE_VAL;
    assign arr.sys_clr      = sys_clr_q;
    assign arr.sys_chain_en = chain_en;

    always_comb begin
        uio_out               = '0;
        uio_out[BIT_BUSY]     = busy;
        uio_out[BIT_DONE]     = done_q;
        uio_out[BIT_OVF]      = ovf;
        uio_out[BIT_RD_VALID] = rd_avail;
    end
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: N=2 and N=4 instances, each attached to a behavioural output-stationary array.
`timescale 1ns/1ps
module tb_tpu_seq_ctrl;
    import tpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]  ui_in_s   [2];
    logic [7:0]  uio_in_s  [2];
    logic [7:0]  uo_out_s  [2];
    logic [7:0]  uio_out_s [2];
    logic [7:0]  uio_oe_s  [2];
    logic [31:0] sa_s      [2];
    logic [31:0] sb_s      [2];
    logic        clr_s     [2];
    logic        cen_s     [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int NN = (gi == 0) ? 2 : 4;

        tpu_seq_ctrl_if #(.N(NN), .DW(8)) arr_if ();
        logic [7:0] uo_w, uio_out_w, uio_oe_w;

        tpu_seq_ctrl #(.N(NN), .DW(8)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .ui_in   (ui_in_s[gi]),
            .uio_in  (uio_in_s[gi]),
            .uo_out  (uo_w),
            .uio_out (uio_out_w),
            .uio_oe  (uio_oe_w),
            .arr     (arr_if)
        );

        // Array model: A flows right, B flows down, each PE accumulates a*b.
        logic [15:0] acc    [NN][NN];
        logic [7:0]  a_pipe [NN][NN];
        logic [7:0]  b_pipe [NN][NN];
        logic [7:0]  av, bv;
        int          rd_ptr;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n || arr_if.sys_clr) begin
                for (int i = 0; i < NN; i++)
                    for (int j = 0; j < NN; j++) begin
                        acc[i][j]    <= '0;
                        a_pipe[i][j] <= '0;
                        b_pipe[i][j] <= '0;
                    end
                rd_ptr <= 0;
            end else begin
                for (int i = 0; i < NN; i++)
                    for (int j = 0; j < NN; j++) begin
                        if (j == 0) av = arr_if.sys_a[i*8 +: 8];
                        else        av = a_pipe[i][j-1];
                        if (i == 0) bv = arr_if.sys_b[j*8 +: 8];
                        else        bv = b_pipe[i-1][j];
                        acc[i][j]    <= acc[i][j] + av * bv;
                        a_pipe[i][j] <= av;
                        b_pipe[i][j] <= bv;
                    end
                if (arr_if.sys_chain_en) rd_ptr <= rd_ptr + 1;
            end
        end

        assign arr_if.sys_chain_out = (rd_ptr < NN*NN) ? acc[rd_ptr / NN][rd_ptr % NN][7:0] : 8'h00;

        assign uo_out_s[gi]  = uo_w;
        assign uio_out_s[gi] = uio_out_w;
        assign uio_oe_s[gi]  = uio_oe_w;
        assign sa_s[gi]      = 32'(arr_if.sys_a);
        assign sb_s[gi]      = 32'(arr_if.sys_b);
        assign clr_s[gi]     = arr_if.sys_clr;
        assign cen_s[gi]     = arr_if.sys_chain_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic [1:0] mode, input logic stb, input logic [7:0] data);
        uio_in_s[inst] = {5'b0, stb, mode};
        ui_in_s[inst]  = data;
    endtask

    task automatic set_mode(input int inst, input logic [1:0] mode);
        drive(inst, mode, 1'b0, 8'h00);
        step();
    endtask

    task automatic strobe_byte(input int inst, input logic [1:0] mode, input logic [7:0] data);
        drive(inst, mode, 1'b1, data);
        step();
        drive(inst, mode, 1'b0, data);
        step();
    endtask

    task automatic n2_compute_read();
        set_mode(0, MODE_COMPUTE);
        repeat (4) step();
        chk("n2_done_after_4", 32'(uio_out_s[0][BIT_DONE]), 32'd1);
        exp_q.push_back(8'd19); exp_q.push_back(8'd22);
        exp_q.push_back(8'd43); exp_q.push_back(8'd50);
        set_mode(0, MODE_READ);
        repeat (4) strobe_byte(0, MODE_READ, 8'h00);
        chk("n2_rd_valid_end", 32'(uio_out_s[0][BIT_RD_VALID]), 32'd0);
    endtask

    logic ovf_exp;

    initial begin
`ifdef TPU_SEQ_CTRL_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        rst_n = 1'b0;
        drive(0, MODE_LOAD_A, 1'b0, 8'h00);
        drive(1, MODE_LOAD_A, 1'b0, 8'h00);

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    if (cen_s[k]) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rd_unexpected inst%0d: got uo_out 0x%0h, expected no read", k, uo_out_s[k]);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            chk($sformatf("rd_data_inst%0d", k), 32'(uo_out_s[k]), 32'(mon_exp));
                            chk($sformatf("rd_valid_inst%0d", k), 32'(uio_out_s[k][BIT_RD_VALID]), 32'd1);
                        end
                    end
                end
            end
        join_none

        step(); step();
        chk("rst_uio_out", 32'(uio_out_s[0]), 32'h00);
        chk("rst_uo_out",  32'(uo_out_s[0]),  32'h00);
        chk("rst_uio_oe",  32'(uio_oe_s[0]),  32'hF0);
        chk("rst_sys_ab",  sa_s[0] | sb_s[0], 32'h0);
        rst_n = 1'b1;
        step();
        chk("load_a_entry_clr", 32'(clr_s[0]), 32'd1);
        step();
        chk("load_a_clr_one_cycle", 32'(clr_s[0]), 32'd0);

        // Basic 2x2 multiply
        for (int k = 1; k <= 4; k++) strobe_byte(0, MODE_LOAD_A, 8'(k));
        set_mode(0, MODE_LOAD_B);
        for (int k = 5; k <= 8; k++) strobe_byte(0, MODE_LOAD_B, 8'(k));
        set_mode(0, MODE_COMPUTE);
        chk("n2_busy_t0", 32'(uio_out_s[0]), 32'h10);
        chk("n2_sys_a_t0", sa_s[0], 32'h0001);
        chk("n2_sys_b_t0", sb_s[0], 32'h0005);
        step();
        chk("n2_sys_a_t1", sa_s[0], 32'h0302);
        chk("n2_sys_b_t1", sb_s[0], 32'h0607);
        step();
        chk("n2_sys_a_t2", sa_s[0], 32'h0400);
        chk("n2_sys_b_t2", sb_s[0], 32'h0800);
        step();
        chk("n2_busy_t3", 32'(uio_out_s[0][BIT_BUSY]), 32'd1);
        step();
        chk("n2_done_status", 32'(uio_out_s[0]), 32'h20);
        chk("n2_done_sys_a", sa_s[0], 32'h0);
        exp_q.push_back(8'd19); exp_q.push_back(8'd22);
        exp_q.push_back(8'd43); exp_q.push_back(8'd50);
        set_mode(0, MODE_READ);
        chk("n2_read_head", 32'(uo_out_s[0]), 32'd19);
        repeat (4) strobe_byte(0, MODE_READ, 8'h00);
        chk("n2_read_end_status", 32'(uio_out_s[0]), 32'h20);
        chk("n2_read_end_uo", 32'(uo_out_s[0]), 32'h00);
        drive(0, MODE_READ, 1'b1, 8'h00);
        #1;
        chk("n2_read_extra_strobe", 32'(cen_s[0]), 32'd0);
        step();
        drive(0, MODE_READ, 1'b0, 8'h00);
        step();

        // Overflowing load of A, held strobe in LOAD_B
        set_mode(0, MODE_LOAD_A);
        chk("reload_done_clear", 32'(uio_out_s[0][BIT_DONE]), 32'd0);
        for (int k = 1; k <= 4; k++) strobe_byte(0, MODE_LOAD_A, 8'(k));
        chk("ovf_before_drop", 32'(uio_out_s[0][BIT_OVF]), 32'd0);
        strobe_byte(0, MODE_LOAD_A, 8'd99);
        chk("ovf_after_drop", 32'(uio_out_s[0][BIT_OVF]), 32'(ovf_exp));
        set_mode(0, MODE_LOAD_B);
        drive(0, MODE_LOAD_B, 1'b1, 8'd5);
        repeat (3) step();
        drive(0, MODE_LOAD_B, 1'b0, 8'd5);
        step();
        for (int k = 6; k <= 8; k++) strobe_byte(0, MODE_LOAD_B, 8'(k));
        n2_compute_read();
        chk("ovf_sticky", 32'(uio_out_s[0][BIT_OVF]), 32'(ovf_exp));

        // Abort at step 1
        set_mode(0, MODE_COMPUTE);
        step();
        drive(0, MODE_LOAD_A, 1'b0, 8'h00);
        step();
        chk("abort_clr", 32'(clr_s[0]), 32'd1);
        chk("abort_status", 32'(uio_out_s[0] & 8'hB0), 32'h00);
        chk("abort_sys_ab", sa_s[0] | sb_s[0], 32'h0);
        step();
        chk("abort_clr_one_cycle", 32'(clr_s[0]), 32'd0);

        // Reset at compute step 2
        set_mode(0, MODE_COMPUTE);
        step(); step();
        chk("pre_rst_sys_a_t2", sa_s[0], 32'h0400);
        rst_n = 1'b0;
        drive(0, MODE_LOAD_A, 1'b0, 8'h00);
        #1;
        chk("midrst_uio_out", 32'(uio_out_s[0]), 32'h00);
        chk("midrst_uo_out",  32'(uo_out_s[0]),  32'h00);
        chk("midrst_uio_oe",  32'(uio_oe_s[0]),  32'hF0);
        chk("midrst_sys_ab",  sa_s[0] | sb_s[0], 32'h0);
        chk("midrst_sys_clr", 32'(clr_s[0]), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("postrst_status", 32'(uio_out_s[0]), 32'h00);
        step();

        // N=4: identity x (1..16)
        for (int k = 0; k < 16; k++) strobe_byte(1, MODE_LOAD_A, (k % 5 == 0) ? 8'd1 : 8'd0);
        set_mode(1, MODE_LOAD_B);
        for (int k = 1; k <= 16; k++) strobe_byte(1, MODE_LOAD_B, 8'(k));
        set_mode(1, MODE_COMPUTE);
        chk("n4_sys_a_t0", sa_s[1], 32'h00000001);
        step();
        chk("n4_sys_b_t1", sb_s[1], 32'h00000205);
        repeat (8) step();
        chk("n4_busy_t9", 32'(uio_out_s[1]), 32'h10);
        step();
        chk("n4_done", 32'(uio_out_s[1]), 32'h20);
        for (int k = 1; k <= 16; k++) exp_q.push_back(8'(k));
        set_mode(1, MODE_READ);
        repeat (16) strobe_byte(1, MODE_READ, 8'h00);
        chk("n4_rd_valid_end", 32'(uio_out_s[1][BIT_RD_VALID]), 32'd0);

        step(); step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
